// File: rtl/z_muldiv_unit.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply, restoring divide on magnitudes.
// Operand A comes from the Y register, operand B from the bus; the result is held in the Z pair.
module z_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] bus_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_low
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    iterCnt;
    logic             isDiv;
    logic             divZero;
    logic             aNeg;
    logic             bNeg;
    logic             qm1;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] lowReg;
    logic [WIDTH:0]   accReg;

    logic [WIDTH:0]   aExt;
    logic [WIDTH:0]   boothSum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quotFix;
    logic [WIDTH-1:0] remFix;
    logic [WIDTH-1:0] absY;
    logic [WIDTH-1:0] absBus;

    // The accumulator carries one extra bit so that subtracting MIN cannot overflow.
    always_comb begin
        aExt     = {opA[WIDTH-1], opA};
        boothSum = accReg;
        case ({lowReg[0], qm1})
            2'b01:   boothSum = accReg + aExt;
            2'b10:   boothSum = accReg - aExt;
            default: boothSum = accReg;
        endcase
        remShift = {accReg[WIDTH-1:0], lowReg[WIDTH-1]};
        trial    = remShift - {1'b0, absB};
        quotFix  = (aNeg ^ bNeg) ? WIDTH'(0) - lowReg : lowReg;
        remFix   = aNeg ? WIDTH'(0) - accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
        absY     = y_in[WIDTH-1] ? WIDTH'(0) - y_in : y_in;
        absBus   = bus_in[WIDTH-1] ? WIDTH'(0) - bus_in : bus_in;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            iterCnt     <= '0;
            isDiv       <= 1'b0;
            divZero     <= 1'b0;
            aNeg        <= 1'b0;
            bNeg        <= 1'b0;
            qm1         <= 1'b0;
            opA         <= '0;
            absB        <= '0;
            lowReg      <= '0;
            accReg      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            z_hi        <= '0;
            z_low       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opA         <= y_in;
                        isDiv       <= div_sel;
                        aNeg        <= y_in[WIDTH-1];
                        bNeg        <= bus_in[WIDTH-1];
                        absB        <= absBus;
                        accReg      <= '0;
                        qm1         <= 1'b0;
                        lowReg      <= div_sel ? absY : bus_in;
                        iterCnt     <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        // A zero divisor skips the iterations and finishes from FIX.
                        if (div_sel && (bus_in == '0)) begin
                            divZero <= 1'b1;
                            state   <= FIX;
                        end else begin
                            divZero <= 1'b0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (isDiv) begin
                        if (!trial[WIDTH]) begin
                            accReg <= trial;
                            lowReg <= {lowReg[WIDTH-2:0], 1'b1};
                        end else begin
                            accReg <= remShift;
                            lowReg <= {lowReg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        accReg <= {boothSum[WIDTH], boothSum[WIDTH:1]};
                        lowReg <= {boothSum[0], lowReg[WIDTH-1:1]};
                        qm1    <= lowReg[0];
                    end
                    iterCnt <= iterCnt + CW'(1);
                    if (iterCnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (divZero) begin
                        z_hi        <= opA;
                        z_low       <= '1;
                        div_by_zero <= 1'b1;
                    end else if (isDiv) begin
                        z_hi  <= remFix;
                        z_low <= quotFix;
                    end else begin
                        z_hi  <= accReg[WIDTH-1:0];
                        z_low <= lowReg;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z_muldiv_unit.sv
// Scoreboard bench for z_muldiv_unit: stimulus pushes reference results, a monitor pops them on done.
module tb_z_muldiv_unit;

    logic        clock;
    logic        clear;
    logic        start;
    logic        div_sel;
    logic [31:0] y_in;
    logic [31:0] bus_in;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] z_hi;
    logic [31:0] z_low;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   nChecks = 0;
    int   nPass   = 0;

    z_muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .div_sel(div_sel),
        .y_in(y_in), .bus_in(bus_in), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .z_hi(z_hi), .z_low(z_low)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: plain signed 64-bit arithmetic; SV division truncates toward zero.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic dv);
        exp_t        e;
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        e.dbz = 1'b0;
        if (!dv) begin
            p    = 64'(sa * sb);
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else begin
            q    = 64'(sa / sb);
            r    = 64'(sa % sb);
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (clear === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                me = sbq.pop_front();
                chk("z_hi", 64'(z_hi), 64'(me.hi));
                chk("z_low", 64'(z_low), 64'(me.lo));
                chk("div_by_zero", 64'(div_by_zero), 64'(me.dbz));
            end
        end
    end

    // Issue one operation and watch latency, busy, and Z stability; pulseAt>0 injects an ignored start.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic dv, input int pulseAt);
        int          k;
        int          lat;
        logic        busyOk;
        logic        zOk;
        logic [31:0] zh0;
        logic [31:0] zl0;
        @(negedge clock);
        zh0     = z_hi;
        zl0     = z_low;
        y_in    = a;
        bus_in  = b;
        div_sel = dv;
        start   = 1'b1;
        sbq.push_back(model(a, b, dv));
        @(posedge clock);
        #1;
        start   = 1'b0;
        y_in    = $urandom;
        bus_in  = $urandom;
        div_sel = 1'($urandom);
        chk("dbz_cleared_on_start", 64'(div_by_zero), 64'd0);
        lat    = (dv && b == 32'd0) ? 1 : 33;
        busyOk = 1'b1;
        zOk    = 1'b1;
        k      = 0;
        while (k < 100) begin
            @(posedge clock);
            #1;
            k++;
            start = 1'b0;
            if (done) break;
            if (!busy) busyOk = 1'b0;
            if (z_hi !== zh0 || z_low !== zl0) zOk = 1'b0;
            if (k == pulseAt) begin
                start   = 1'b1;
                y_in    = $urandom;
                bus_in  = $urandom;
                div_sel = 1'($urandom);
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(done), 64'd1);
        chk("latency", 64'(k), 64'(lat));
        chk("busy_low_on_done", 64'(busy), 64'd0);
        chk("busy_during_run", 64'(busyOk), 64'd1);
        chk("z_stable_during_run", 64'(zOk), 64'd1);
        @(posedge clock);
        #1;
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pickOp();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clock   = 1'b0;
        clear   = 1'b0;
        start   = 1'b0;
        div_sel = 1'b0;
        y_in    = '0;
        bus_in  = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_z", {z_hi, z_low}, 64'd0);
        @(negedge clock);
        clear = 1'b1;

        runOp(32'd7, 32'hFFFF_FFFD, 1'b0, 0);
        runOp(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        runOp(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 0);
        runOp(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        runOp(32'd100, 32'd7, 1'b1, 0);
        runOp(32'd5, 32'd0, 1'b1, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("dbz_holds", 64'(div_by_zero), 64'd1);
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5);
        runOp(32'd100, 32'd7, 1'b1, 0);

        // Abort a multiply mid-run with clear.
        @(negedge clock);
        y_in    = 32'd3;
        bus_in  = 32'd4;
        div_sel = 1'b0;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_z", {z_hi, z_low}, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("abort_held_busy", 64'(busy), 64'd0);
        @(negedge clock);
        clear = 1'b1;
        runOp(32'd3, 32'd4, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            runOp(pickOp(), pickOp(), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
        end

        repeat (4) @(posedge clock);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
